// File: rtl/gg264_pkg.sv
// Shared types and constants for the start-code scanner.
//   byte_word_t  : one 16-byte word, byte 0 first in the stream
//   byte_mask_t  : one bit per byte of a word, bit 0 belongs to byte 0
//   START_CODE   : the 3-byte Annex-B start code 00 00 01
//   scan_state_t : SEARCH (before the first NAL header) / IN_NAL
package gg264_pkg;

   localparam logic [23:0] START_CODE = 24'h000001;

   typedef logic [0:15][7:0] byte_word_t;
   typedef logic [0:15]      byte_mask_t;

   typedef enum logic {
      SEARCH = 1'b0,
      IN_NAL = 1'b1
   } scan_state_t;

endpackage

// File: rtl/gg_sc_match.sv
// Combinational start-code matcher over an 18-byte window made of the last
// two bytes of the previous word followed by the 16 bytes of the current one.
//   win      : window bytes, win[0..1] = history, win[2..17] = current word
//   win_flag : "0x03 removed before this byte"; index 0 is never consulted
//              because only bytes b and c of a code can be protected
//   match    : match[j] = code with a=win[j], b=win[j+1], c=win[j+2]
//   clear    : window bytes that belong to any detected code
//   sos      : sos[k] = current-word byte k is a NAL header byte;
//              sos[BYTES] means the header byte lies in the next word
module gg_sc_match
   import gg264_pkg::*;
#(
   parameter int BYTES = 16
)
(
   input  logic [0:BYTES+1][7:0] win,
   input  logic [1:BYTES+1]      win_flag,
   output logic [0:BYTES-1]      match,
   output logic [0:BYTES+1]      clear,
   output logic [1:BYTES]        sos
);

   always_comb begin
      match = '0;
      clear = '0;
      sos   = '0;
      for (int j = 0; j < BYTES; j++) begin
         // A flag on b or c means the encoder inserted 0x03 here, so the
         // byte pattern is payload rather than a real start code.
         if (({win[j], win[j+1], win[j+2]} == START_CODE) &&
             !win_flag[j+1] && !win_flag[j+2]) begin
            match[j]   = 1'b1;
            clear[j]   = 1'b1;
            clear[j+1] = 1'b1;
            clear[j+2] = 1'b1;
            // c sits at window j+2 = word byte j, so the header is word byte j+1
            sos[j+1]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gg_start_code_scan.sv
// Start-code scanner: finds 00 00 01 in the emulation-removed byte stream,
// marks start-code bytes as not kept, flags NAL header bytes and counts NALs.
//   clk, reset        : clock, synchronous active-high reset
//   iport/_flag/_last : input word, per-byte "0x03 removed" flags, last word
//   iport_valid/ready : input handshake
//   oport/_keep/_sos  : output word (one word late), keep and header masks
//   oport_last        : last word of the stream
//   oport_valid/ready : output handshake
//   nal_count         : start codes seen since reset, wraps
//
// Handshake: a word moves on a port at a rising edge where valid and ready are
// both high. oport_valid, once raised, stays high with oport/keep/sos/last
// unchanged until oport_ready is seen high. iport_ready never depends on
// iport_valid.
//
// Each word waits in the hold register H until the next word arrives, because
// a code straddling the boundary must retroactively clear H[14..15].
module gg_start_code_scan
   import gg264_pkg::*;
#(
   parameter int BYTES = 16,
   parameter int CNT_W = 16
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [0:BYTES-1][7:0] iport,
   input  logic [0:BYTES-1]      iport_flag,
   input  logic                  iport_last,
   input  logic                  iport_valid,
   output logic                  iport_ready,
   output logic [0:BYTES-1][7:0] oport,
   output logic [0:BYTES-1]      oport_keep,
   output logic [0:BYTES-1]      oport_sos,
   output logic                  oport_last,
   output logic                  oport_valid,
   input  logic                  oport_ready,
   output logic [CNT_W-1:0]      nal_count
);

   // Hold register
   byte_word_t  h_data;
   byte_mask_t  h_keep;
   byte_mask_t  h_sos;
   logic        h_flag_last;   // flag of H[15]; the only history flag a code can use
   logic        h_last;
   logic        h_valid;

   scan_state_t state, state_next;
   logic        pend_sos;
   logic        drain;

   logic [0:BYTES+1][7:0] win;
   logic [1:BYTES+1]      win_flag;
   logic [0:BYTES-1]      match;
   logic [0:BYTES+1]      clear;
   logic [1:BYTES]        sos_mask;

   byte_mask_t  w_keep;
   byte_mask_t  w_sos;
   byte_mask_t  hist_clear;
   logic        run_nal;
   logic [4:0]  match_cnt;
   logic        accept;
   logic        o_free;

   assign o_free      = !oport_valid || oport_ready;
   assign iport_ready = !drain && o_free;
   assign accept      = iport_valid && iport_ready;

   // With H empty (start of a stream) the history must not complete a code,
   // so it reads as non-zero bytes with no flags.
   always_comb begin
      win[0]              = h_valid ? h_data[BYTES-2] : 8'hFF;
      win[1]              = h_valid ? h_data[BYTES-1] : 8'hFF;
      win[2:BYTES+1]      = iport;
      win_flag[1]         = h_valid && h_flag_last;
      win_flag[2:BYTES+1] = iport_flag;
   end

   gg_sc_match #(.BYTES(BYTES)) u_match (
      .win      (win),
      .win_flag (win_flag),
      .match    (match),
      .clear    (clear),
      .sos      (sos_mask)
   );

   always_comb begin
      match_cnt = '0;
      for (int j = 0; j < BYTES; j++) begin
         match_cnt = match_cnt + {4'd0, match[j]};
      end
   end

   // Codes whose a/b bytes lie in H clear those bytes on their way to O.
   assign hist_clear = {{(BYTES-2){1'b0}}, clear[0], clear[1]};

   // Byte-ordered walk: the scanner enters IN_NAL at the first header byte
   // and keeps everything from there on, except bytes of a start code.
   always_comb begin
      w_sos   = {pend_sos, sos_mask[1:BYTES-1]};
      run_nal = (state == IN_NAL);
      w_keep  = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (w_sos[i]) begin
            run_nal = 1'b1;
         end
         w_keep[i] = run_nal && !clear[i+2];
      end
      state_next = state;
      if (accept) begin
         state_next = iport_last ? SEARCH : (run_nal ? IN_NAL : SEARCH);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SEARCH;
         pend_sos    <= 1'b0;
         drain       <= 1'b0;
         h_valid     <= 1'b0;
         h_data      <= '0;
         h_keep      <= '0;
         h_sos       <= '0;
         h_flag_last <= 1'b0;
         h_last      <= 1'b0;
         oport       <= '0;
         oport_keep  <= '0;
         oport_sos   <= '0;
         oport_last  <= 1'b0;
         oport_valid <= 1'b0;
         nal_count   <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            nal_count   <= nal_count + CNT_W'(match_cnt);
            pend_sos    <= sos_mask[BYTES] && !iport_last;
            h_data      <= iport;
            h_keep      <= w_keep;
            h_sos       <= w_sos;
            h_flag_last <= iport_flag[BYTES-1];
            h_last      <= iport_last;
            h_valid     <= 1'b1;
            drain       <= iport_last;
            if (h_valid) begin
               oport       <= h_data;
               oport_keep  <= h_keep & ~hist_clear;
               oport_sos   <= h_sos;
               oport_last  <= h_last;
               oport_valid <= 1'b1;
            end else if (oport_ready) begin
               oport_valid <= 1'b0;
            end
         end else if (drain && o_free) begin
            // The last word has no successor, so it leaves H on its own.
            oport       <= h_data;
            oport_keep  <= h_keep;
            oport_sos   <= h_sos;
            oport_last  <= h_last;
            oport_valid <= 1'b1;
            h_valid     <= 1'b0;
            drain       <= 1'b0;
         end else if (oport_ready) begin
            oport_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gg_start_code_scan.sv
// Bench for gg_start_code_scan: directed cases plus random streams checked
// against a byte-stream model of start-code detection.
module tb_gg_start_code_scan;

   localparam int TIMEOUT = 2000;

   logic             clk = 1'b0;
   logic             reset;
   logic [0:15][7:0] iport;
   logic [0:15]      iport_flag;
   logic             iport_last;
   logic             iport_valid;
   logic             iport_ready;
   logic [0:15][7:0] oport;
   logic [0:15]      oport_keep;
   logic [0:15]      oport_sos;
   logic             oport_last;
   logic             oport_valid;
   logic             oport_ready;
   logic [15:0]      nal_count;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   gg_start_code_scan #(.BYTES(16), .CNT_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .iport       (iport),
      .iport_flag  (iport_flag),
      .iport_last  (iport_last),
      .iport_valid (iport_valid),
      .iport_ready (iport_ready),
      .oport       (oport),
      .oport_keep  (oport_keep),
      .oport_sos   (oport_sos),
      .oport_last  (oport_last),
      .oport_valid (oport_valid),
      .oport_ready (oport_ready),
      .nal_count   (nal_count)
   );

   // ---------------- bookkeeping ----------------
   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      total_cnt++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   task automatic finish_run();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   endtask

   // ---------------- stream model ----------------
   logic [7:0]  s_data [256];
   bit          s_flag [256];
   int          s_words;
   logic [0:15] m_keep [16];
   logic [0:15] m_sos  [16];
   int          m_cnt  [16];

   // Whole-stream view: a code is any 00 00 01 at c>=2 whose b and c are not
   // protected; the header byte follows c; nothing is kept before the first
   // header byte and code bytes are never kept.
   task automatic build_model();
      bit clr [256];
      bit sos [256];
      bit seen;
      int n;
      n = s_words * 16;
      for (int i = 0; i < n; i++) begin
         clr[i] = 1'b0;
         sos[i] = 1'b0;
      end
      for (int w = 0; w < s_words; w++) m_cnt[w] = 0;
      for (int c = 2; c < n; c++) begin
         if (s_data[c-2] == 8'h00 && s_data[c-1] == 8'h00 && s_data[c] == 8'h01 &&
             !s_flag[c-1] && !s_flag[c]) begin
            clr[c-2] = 1'b1;
            clr[c-1] = 1'b1;
            clr[c]   = 1'b1;
            if (c + 1 < n) sos[c+1] = 1'b1;
            m_cnt[c/16]++;
         end
      end
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (sos[i]) seen = 1'b1;
         m_keep[i/16][i%16] = seen && !clr[i];
         m_sos[i/16][i%16]  = sos[i];
      end
   endtask

   task automatic fill(input int nw, input logic [7:0] v);
      s_words = nw;
      for (int i = 0; i < nw * 16; i++) begin
         s_data[i] = v;
         s_flag[i] = 1'b0;
      end
   endtask

   task automatic fill_random(input int nw);
      int r;
      s_words = nw;
      for (int i = 0; i < nw * 16; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      s_data[i] = 8'h00;
         else if (r < 6) s_data[i] = 8'h01;
         else            s_data[i] = 8'($urandom_range(2, 255));
         s_flag[i] = ($urandom_range(0, 9) == 0);
      end
   endtask

   function automatic logic [0:15][7:0] word_of(input int w);
      logic [0:15][7:0] d;
      for (int i = 0; i < 16; i++) d[i] = s_data[w*16+i];
      return d;
   endfunction

   function automatic logic [0:15] flags_of(input int w);
      logic [0:15] f;
      for (int i = 0; i < 16; i++) f[i] = s_flag[w*16+i];
      return f;
   endfunction

   // ---------------- scoreboard ----------------
   logic [0:15][7:0] exp_data_q [$];
   logic [0:15]      exp_keep_q [$];
   logic [0:15]      exp_sos_q  [$];
   logic             exp_last_q [$];
   int               cnt_q      [$];
   logic [15:0]      exp_cnt      = '0;
   bit               chk_en       = 1'b0;
   bit               hold_pending = 1'b0;
   bit               post_last    = 1'b0;
   logic [160:0]     held;

   always @(negedge clk) begin
      if (chk_en) begin
         check("nal_count", 192'(nal_count), 192'(exp_cnt));
         if (hold_pending) begin
            check("stall_valid", 192'(oport_valid), 192'(1'b1));
            check("stall_stable", 192'({oport, oport_keep, oport_sos, oport_last}), 192'(held));
         end
         hold_pending = oport_valid && !oport_ready;
         held = {oport, oport_keep, oport_sos, oport_last};
         if (oport_valid && oport_ready) begin
            if (exp_data_q.size() == 0) begin
               fail_now("unexpected_output_word");
            end else begin
               check("out_data", 192'(oport), 192'(exp_data_q.pop_front()));
               check("out_keep", 192'(oport_keep), 192'(exp_keep_q.pop_front()));
               check("out_sos", 192'(oport_sos), 192'(exp_sos_q.pop_front()));
               check("out_last", 192'(oport_last), 192'(exp_last_q.pop_front()));
            end
         end
         if (post_last) check("drain_ready_low", 192'(iport_ready), 192'(1'b0));
         post_last = 1'b0;
         if (iport_valid && iport_ready) begin
            if (cnt_q.size() != 0) exp_cnt = exp_cnt + 16'(cnt_q.pop_front());
            post_last = iport_last;
         end
      end
   end

   // ---------------- drivers ----------------
   int rdy_mode = 0;   // 0 always ready, 1 toggling, 2 random
   int gap_max  = 0;

   initial begin
      oport_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       oport_ready = 1'b1;
            1:       oport_ready = ~oport_ready;
            default: oport_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic drive_word(input logic [0:15][7:0] d, input logic [0:15] f, input logic l);
      int waitc;
      iport       = d;
      iport_flag  = f;
      iport_last  = l;
      iport_valid = 1'b1;
      waitc = 0;
      @(negedge clk);
      while (!iport_ready && waitc < TIMEOUT) begin
         waitc++;
         @(negedge clk);
      end
      if (!iport_ready) begin
         fail_now("input_accept_timeout");
         finish_run();
      end
      @(posedge clk);
      #1;
      iport_valid = 1'b0;
      iport_last  = 1'b0;
      repeat ($urandom_range(0, gap_max)) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_stream(input bit with_last);
      for (int w = 0; w < s_words; w++) begin
         exp_data_q.push_back(word_of(w));
         exp_keep_q.push_back(m_keep[w]);
         exp_sos_q.push_back(m_sos[w]);
         exp_last_q.push_back(with_last && (w == s_words - 1));
         cnt_q.push_back(m_cnt[w]);
      end
      for (int w = 0; w < s_words; w++) begin
         drive_word(word_of(w), flags_of(w), with_last && (w == s_words - 1));
      end
   endtask

   task automatic wait_drain();
      int waitc;
      waitc = 0;
      while (exp_data_q.size() != 0 && waitc < TIMEOUT) begin
         @(negedge clk);
         waitc++;
      end
      if (exp_data_q.size() != 0) begin
         fail_now("output_drain_timeout");
         finish_run();
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- test sequence ----------------
   logic [15:0] base;

   initial begin
      reset       = 1'b1;
      iport       = '0;
      iport_flag  = '0;
      iport_last  = 1'b0;
      iport_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_oport_valid", 192'(oport_valid), 192'(1'b0));
      check("rst_nal_count", 192'(nal_count), 192'(16'd0));
      check("rst_oport", 192'(oport), 192'(0));
      check("rst_keep_sos_last", 192'({oport_keep, oport_sos, oport_last}), 192'(0));
      check("rst_iport_ready", 192'(iport_ready), 192'(1'b1));
      @(posedge clk);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;

      // Single-word stream with a code at the very start.
      fill(1, 8'h11);
      s_data[0] = 8'h00; s_data[1] = 8'h00; s_data[2] = 8'h01; s_data[3] = 8'h67;
      build_model();
      check("pin_single_keep", 192'(m_keep[0]), 192'(16'h1FFF));
      check("pin_single_sos", 192'(m_sos[0]), 192'(16'h1000));
      send_stream(1'b1);
      @(negedge clk);
      check("single_not_out_yet", 192'(oport_valid), 192'(1'b0));
      @(negedge clk);
      check("single_last_out", 192'({oport_valid, oport_last}), 192'(2'b11));
      wait_drain();
      check("single_count", 192'(nal_count), 192'(16'd1));

      // Code straddling a word boundary, inside a NAL.
      base = exp_cnt;
      fill(3, 8'h22);
      s_data[0] = 8'h00; s_data[1] = 8'h00; s_data[2] = 8'h01; s_data[3] = 8'h09;
      s_data[30] = 8'h00; s_data[31] = 8'h00; s_data[32] = 8'h01; s_data[33] = 8'h41;
      build_model();
      check("pin_straddle_keep_a", 192'(m_keep[1]), 192'(16'hFFFC));
      check("pin_straddle_keep_b", 192'(m_keep[2]), 192'(16'h7FFF));
      check("pin_straddle_sos_b", 192'(m_sos[2]), 192'(16'h4000));
      send_stream(1'b1);
      wait_drain();
      check("straddle_count", 192'(nal_count), 192'(base + 16'd2));

      // Code ending on byte 15: header byte is byte 0 of the next word.
      base = exp_cnt;
      fill(2, 8'h22);
      s_data[0] = 8'h00; s_data[1] = 8'h00; s_data[2] = 8'h01; s_data[3] = 8'h09;
      s_data[13] = 8'h00; s_data[14] = 8'h00; s_data[15] = 8'h01; s_data[16] = 8'h65;
      build_model();
      check("pin_end15_keep_a", 192'(m_keep[0]), 192'(16'h1FF8));
      check("pin_end15_sos_b", 192'(m_sos[1]), 192'(16'h8000));
      check("pin_end15_keep_b", 192'(m_keep[1]), 192'(16'hFFFF));
      send_stream(1'b1);
      wait_drain();
      check("end15_count", 192'(nal_count), 192'(base + 16'd2));

      // Emulation-protected pattern inside a NAL.
      base = exp_cnt;
      fill(2, 8'h22);
      s_data[0] = 8'h00; s_data[1] = 8'h00; s_data[2] = 8'h01; s_data[3] = 8'h09;
      s_data[21] = 8'h00; s_data[22] = 8'h00; s_data[23] = 8'h01; s_flag[23] = 1'b1;
      build_model();
      check("pin_emul_keep", 192'(m_keep[1]), 192'(16'hFFFF));
      check("pin_emul_sos", 192'(m_sos[1]), 192'(16'h0000));
      send_stream(1'b1);
      wait_drain();
      check("emul_count", 192'(nal_count), 192'(base + 16'd1));

      // Backpressure with toggling ready.
      rdy_mode = 1;
      fill_random(8);
      build_model();
      send_stream(1'b1);
      wait_drain();

      // Random streams, random ready and input gaps.
      rdy_mode = 2;
      gap_max  = 2;
      for (int k = 0; k < 40; k++) begin
         fill_random($urandom_range(1, 6));
         build_model();
         send_stream(1'b1);
      end
      wait_drain();

      // Five back-to-back codes in one word, then reset mid-stream.
      rdy_mode = 0;
      gap_max  = 0;
      repeat (2) @(posedge clk);
      #1;
      base = exp_cnt;
      fill(2, 8'h22);
      for (int i = 0; i < 5; i++) begin
         s_data[16+3*i]   = 8'h00;
         s_data[16+3*i+1] = 8'h00;
         s_data[16+3*i+2] = 8'h01;
      end
      s_data[31] = 8'h55;
      build_model();
      check("pin_multi_sos", 192'(m_sos[1]), 192'(16'h1249));
      check("pin_multi_keep", 192'(m_keep[1]), 192'(16'h0001));
      check("pin_multi_cnt", 192'(m_cnt[1]), 192'(5));
      send_stream(1'b0);
      reset  = 1'b1;
      chk_en = 1'b0;
      @(negedge clk);
      check("multi_count", 192'(nal_count), 192'(base + 16'd5));
      @(posedge clk);
      #1;
      check("mid_rst_valid", 192'(oport_valid), 192'(1'b0));
      check("mid_rst_count", 192'(nal_count), 192'(16'd0));
      check("mid_rst_outputs", 192'({oport, oport_keep, oport_sos, oport_last}), 192'(0));
      reset = 1'b0;
      exp_data_q.delete();
      exp_keep_q.delete();
      exp_sos_q.delete();
      exp_last_q.delete();
      cnt_q.delete();
      exp_cnt      = '0;
      hold_pending = 1'b0;
      post_last    = 1'b0;
      chk_en       = 1'b1;

      // After reset the history is empty: a leading 01 completes nothing.
      fill(1, 8'h33);
      s_data[0] = 8'h01;
      build_model();
      send_stream(1'b1);
      wait_drain();
      check("post_rst_count", 192'(nal_count), 192'(16'd0));

      rdy_mode = 2;
      gap_max  = 1;
      for (int k = 0; k < 10; k++) begin
         fill_random($urandom_range(1, 4));
         build_model();
         send_stream(1'b1);
      end
      wait_drain();

      finish_run();
   end

endmodule

// File: doc/gg_start_code_scan.md
Name: gg_start_code_scan

Overview:
- Consumes the emulation-removed byte stream: 16 bytes per word, each byte carrying a flag that marks an 0x03 removed immediately before it.
- Detects 3-byte start codes 00 00 01 anywhere in the stream, including codes that straddle a word boundary.
- Marks start-code bytes as not-kept, marks each NAL header byte, and counts NAL units.
- Sits directly downstream of the emulation remover and feeds the NAL header/slice parser.

Parameters:
- BYTES, 16, bytes per word; the block is built and verified only at 16.
- CNT_W, 16, width of nal_count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- iport  in  [0:15][7:0]  big-endian bytes; byte 0 is first in the stream
- iport_flag  in  [0:15]  1 = 0x03 was removed before this byte
- iport_last  in  1  last word of the stream
- iport_valid  in  1  input word valid
- iport_ready  out  1  input word accepted when valid & ready
- oport  out  [0:15][7:0]  data, delayed one word
- oport_keep  out  [0:15]  1 = byte belongs to a NAL (header or payload)
- oport_sos  out  [0:15]  1 = byte is a NAL header byte (first byte after 01)
- oport_last  out  1  last word of the stream
- oport_valid  out  1  output word valid
- oport_ready  in  1  downstream accepts the output word
- nal_count  out  CNT_W  start codes detected since reset; wraps

Behaviour:
- Decided interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: oport_valid=0, oport_keep=0, oport_sos=0, oport_last=0, oport=0, nal_count=0. Hold register empty, pending-sos cleared, history cleared, state SEARCH.
- Pipeline: hold register H (one word plus keep/sos/last) feeds output register O.
  - Input word W(n) is released to O only when W(n+1) is accepted, or when W(n) has last set.
  - The one-word delay exists so that start-code bytes in H[14..15] can be cleared retroactively.
- Match window: 18 bytes = H[14], H[15], W[0..15].
  - A match at window bytes a, b, c requires values 00, 00, 01.
  - A match is suppressed if flag[b] or flag[c] is set (the sequence was emulation-protected).
  - Only matches with c inside W are evaluated.
  - When H is empty (first word of a stream), the two history bytes read as non-zero.
- Keep:
  - Bytes a, b, c of every match get keep=0, including bytes in H.
  - In SEARCH, all bytes get keep=0 until the first header byte.
  - In IN_NAL, all other bytes get keep=1.
  - Zero bytes before a start code (the 4-byte-code zero and trailing zeros) stay kept.
- sos: the byte after c gets sos=1 and keep=1.
  - If c = W[15], pend_sos is set and applied to byte 0 of the next accepted word.
  - pend_sos is cleared by last.
- State machine (per byte, evaluated in order within the word):
  - SEARCH -> IN_NAL on the first sos byte.
  - IN_NAL stays IN_NAL.
  - The state after accepting a last word is SEARCH, and history is cleared.
- nal_count adds the number of matches in the word (0..6) on each accepted word; it wraps modulo 2^CNT_W.
- Handshake:
  - iport_ready = !drain & (!oport_valid | oport_ready).
  - O loads when empty or when oport_ready is high in the same cycle.
  - Output data and keep/sos/last are held stable while oport_valid & !oport_ready.
- Drain:
  - Accepting a last word sets drain for one pending transfer.
  - Next, H (holding the last word) moves to O when O is free.
  - Then drain clears and iport_ready rises.
- Reset mid-stream discards H, O and pend_sos; no partial word is emitted.
- Back-to-back start codes (00 00 01 00 00 01) each produce sos.
  - In that case the sos byte of the first code is also byte a of the second, so it ends with keep=0 and sos=1.
  - Downstream treats sos as authoritative.

Decomposition:
- Shared package gg264_pkg: typedef byte_word_t ([0:15][7:0]), typedef byte_mask_t ([0:15]), localparam START_CODE = 24'h000001, enum scan_state_t {SEARCH, IN_NAL}.
- One sub-module, gg_sc_match: purely combinational.
  - Inputs: the 18-byte window and flags.
  - Outputs: per-position match vector, clear mask and sos mask.
- The top module holds H, O, state, pend_sos, drain and the counter.

Test Plan:
- Word 0: bytes 0..2 = 00 00 01, byte 3 = 0x67, remaining bytes non-zero, last=1.
  - Output word: keep[0..2]=0, keep[3..15]=1, sos[3]=1.
  - nal_count = 1; oport_last=1 appears 2 cycles after acceptance.
- Straddle: word A ends ... 00 00, word B starts 01 0x41.
  - Word A output has keep[14..15]=0; word B has keep[0]=0, sos[1]=1.
  - nal_count increments once.
- Code ending at byte 15: word A bytes 13..15 = 00 00 01, word B byte 0 = 0x65.
  - Word B has sos[0]=1 via pend_sos.
- Emulated: 00 00 01 with iport_flag set on the 01 byte.
  - No sos; all bytes kept (in IN_NAL); nal_count unchanged.
- Backpressure: stream 8 words with oport_ready toggling 1010...
  - No word is lost or duplicated; output is held stable while stalled.
  - iport_ready is low during the drain cycle after last.
- Multiple codes in one word: five 00 00 01 xx patterns in one word.
  - nal_count += 5; five sos bits set.
  - Reset asserted in the following cycle: oport_valid=0 and nal_count=0 next cycle.
